cache_refill_ctrl: RTL

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl_if.sv | 53 +++++
 rtl/cache_refill_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
//============================================================================
// Module  : cache_refill_ctrl_if
// Brief   : Miss request, refill response and word-wide memory bus bundle.
//           master = refill controller side, slave = cache/memory side.
//           CACHE_CRITICAL_WORD_FIRST_EN adds crit_valid/crit_word.
// Rev     : 1.0  initial release
//============================================================================
interface cache_refill_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_dirty;
  logic [31:0]  victim_addr;
  logic [255:0] victim_data;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [255:0] fill_data;
  logic         busy;
  logic [31:0]  mem_addr;
  logic         mem_re;
  logic         mem_we;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ack;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic         crit_valid;
  logic [31:0]  crit_word;

  modport master (
    input  req_valid, req_addr, req_dirty, victim_addr, victim_data, mem_rdata, mem_ack,
    output req_ready, fill_valid, fill_addr, fill_data, busy,
    output mem_addr, mem_re, mem_we, mem_wdata, crit_valid, crit_word
  );
  modport slave (
    output req_valid, req_addr, req_dirty, victim_addr, victim_data, mem_rdata, mem_ack,
    input  req_ready, fill_valid, fill_addr, fill_data, busy,
    input  mem_addr, mem_re, mem_we, mem_wdata, crit_valid, crit_word
  );
`else
  modport master (
    input  req_valid, req_addr, req_dirty, victim_addr, victim_data, mem_rdata, mem_ack,
    output req_ready, fill_valid, fill_addr, fill_data, busy,
    output mem_addr, mem_re, mem_we, mem_wdata
  );
  modport slave (
    output req_valid, req_addr, req_dirty, victim_addr, victim_data, mem_rdata, mem_ack,
    input  req_ready, fill_valid, fill_addr, fill_data, busy,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );
`endif
endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
//============================================================================
// Module  : cache_refill_ctrl
// Brief   : Services a cache miss: optional 8-beat victim write-back, 8-beat
//           refill, then a one-cycle fill response. Memory strobes are
//           registered. Option macro: CACHE_CRITICAL_WORD_FIRST_EN.
// Rev     : 1.0  initial release
//============================================================================
module cache_refill_ctrl (
  input  logic                clk,
  input  logic                rst,
  cache_refill_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] c_LAST_BEAT = 3'd7;

  state_t       r_state, w_state_nxt;
  logic [2:0]   r_beat, w_beat_nxt;
  logic [26:0]  r_req_blk, w_req_blk;
  logic [26:0]  r_vic_blk, w_vic_blk;
  logic [255:0] r_vic_data, w_vic_data;
  logic [255:0] r_buf, w_buf_nxt;
  logic [2:0]   w_start, w_start_q;
  logic [2:0]   w_fill_word, w_fill_word_nxt;
  logic         w_accept;
  logic         r_mem_re, r_mem_we, w_mem_re_nxt, w_mem_we_nxt;
  logic [31:0]  r_mem_addr, w_mem_addr_nxt;
  logic [31:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic         r_fill_valid;
  logic [31:0]  r_fill_addr;
  logic [255:0] r_fill_data;
  logic         w_unused_bits;

  assign w_accept   = (r_state == IDLE) && bus.req_valid;
  assign w_req_blk  = w_accept ? bus.req_addr[31:5]    : r_req_blk;
  assign w_vic_blk  = w_accept ? bus.victim_addr[31:5] : r_vic_blk;
  assign w_vic_data = w_accept ? bus.victim_data       : r_vic_data;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic [2:0]  r_start;
  logic        r_crit_valid;
  logic [31:0] r_crit_word;

  assign w_start       = w_accept ? bus.req_addr[4:2] : r_start;
  assign w_start_q     = r_start;
  assign w_unused_bits = ^{bus.req_addr[1:0], bus.victim_addr[4:0]};

  // The first FILL beat is always the critical word, so forward it on its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start      <= 3'd0;
      r_crit_valid <= 1'b0;
      r_crit_word  <= 32'd0;
    end else begin
      r_start      <= w_start;
      r_crit_valid <= (r_state == FILL) && bus.mem_ack && (r_beat == 3'd0);
      if ((r_state == FILL) && bus.mem_ack && (r_beat == 3'd0))
        r_crit_word <= bus.mem_rdata;
    end
  end

  assign bus.crit_valid = r_crit_valid;
  assign bus.crit_word  = r_crit_word;
`else
  assign w_start       = 3'd0;
  assign w_start_q     = 3'd0;
  assign w_unused_bits = ^{bus.req_addr[4:0], bus.victim_addr[4:0]};
`endif

  assign w_fill_word = w_start_q + r_beat;

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_buf_nxt       = r_buf;
    w_fill_word_nxt = 3'd0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = bus.req_dirty ? WB : FILL;
          w_beat_nxt  = 3'd0;
        end
      end
      WB: begin
        if (bus.mem_ack) begin
          w_beat_nxt = r_beat + 3'd1;
          if (r_beat == c_LAST_BEAT)
            w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          // Word i of the block lives at bits [255-32i -: 32].
          w_buf_nxt[{~w_fill_word, 5'd0} +: 32] = bus.mem_rdata;
          w_beat_nxt = r_beat + 3'd1;
          if (r_beat == c_LAST_BEAT)
            w_state_nxt = RESP;
        end
      end
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Strobes are registered, so they are derived from the next state/beat.
    w_fill_word_nxt = w_start + w_beat_nxt;
    w_mem_we_nxt    = (w_state_nxt == WB);
    w_mem_re_nxt    = (w_state_nxt == FILL);
    if (w_state_nxt == WB) begin
      w_mem_addr_nxt  = {w_vic_blk, w_beat_nxt, 2'b00};
      w_mem_wdata_nxt = w_vic_data[{~w_beat_nxt, 5'd0} +: 32];
    end else if (w_state_nxt == FILL) begin
      w_mem_addr_nxt  = {w_req_blk, w_fill_word_nxt, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_beat       <= 3'd0;
      r_req_blk    <= 27'd0;
      r_vic_blk    <= 27'd0;
      r_vic_data   <= 256'd0;
      r_buf        <= 256'd0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= 32'd0;
      r_fill_data  <= 256'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
      r_req_blk    <= w_req_blk;
      r_vic_blk    <= w_vic_blk;
      r_vic_data   <= w_vic_data;
      r_buf        <= w_buf_nxt;
      r_mem_re     <= w_mem_re_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_fill_valid <= (w_state_nxt == RESP);
      // The response copy is separate from the staging buffer so it stays
      // stable across the following transaction.
      if (w_state_nxt == RESP) begin
        r_fill_addr <= {r_req_blk, 5'd0};
        r_fill_data <= w_buf_nxt;
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.fill_valid = r_fill_valid;
  assign bus.fill_addr  = r_fill_addr;
  assign bus.fill_data  = r_fill_data;
  assign bus.mem_re     = r_mem_re;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire
